// File: rtl/input_unit.sv
// Router input port: one FIFO per virtual channel, dimension-ordered route
// computation, switch-side outputs and a packet-locking local eject arbiter.
module input_unit #(
  parameter  int VC_NUM     = 2,
  parameter  int FLIT_SIZE  = 64,
  parameter  int ROUTE_LEN  = 3,
  parameter  int FIFO_DEPTH = 4,
  parameter  int COORD_W    = 4,
  parameter  int CUR_X      = 0,
  parameter  int CUR_Y      = 0,
  parameter  int CUR_Z      = 0,
  localparam int VCW        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           link_valid,
  input  logic [VCW-1:0]                 link_vc,
  input  logic [FLIT_SIZE-1:0]           link_flit,
  output logic [VC_NUM-1:0]              link_avail,
  output logic [VC_NUM*FLIT_SIZE-1:0]    out,
  output logic [VC_NUM*ROUTE_LEN-1:0]    route_out,
  output logic [VC_NUM-1:0]              out_valid,
  input  logic [VC_NUM-1:0]              out_avail,
  output logic                           eject_valid,
  output logic [VCW-1:0]                 eject_vc,
  output logic [FLIT_SIZE-1:0]           eject_flit,
  input  logic                           eject_avail
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);
  localparam logic [COORD_W-1:0] CZ = COORD_W'(CUR_Z);

  localparam logic [ROUTE_LEN-1:0] R_LOCAL = ROUTE_LEN'(0);
  localparam logic [ROUTE_LEN-1:0] R_XPOS  = ROUTE_LEN'(1);
  localparam logic [ROUTE_LEN-1:0] R_YPOS  = ROUTE_LEN'(2);
  localparam logic [ROUTE_LEN-1:0] R_ZPOS  = ROUTE_LEN'(3);
  localparam logic [ROUTE_LEN-1:0] R_XNEG  = ROUTE_LEN'(4);
  localparam logic [ROUTE_LEN-1:0] R_YNEG  = ROUTE_LEN'(5);
  localparam logic [ROUTE_LEN-1:0] R_ZNEG  = ROUTE_LEN'(6);

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [ROUTE_LEN-1:0] route_of(
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] dy,
    input logic [COORD_W-1:0] dz
  );
    logic [ROUTE_LEN-1:0] r;
    if (dx > CX)      r = R_XPOS;
    else if (dx < CX) r = R_XNEG;
    else if (dy > CY) r = R_YPOS;
    else if (dy < CY) r = R_YNEG;
    else if (dz > CZ) r = R_ZPOS;
    else if (dz < CZ) r = R_ZNEG;
    else              r = R_LOCAL;
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  function automatic logic [VCW-1:0] vc_inc(input logic [VCW-1:0] v);
    return (v == VCW'(VC_NUM - 1)) ? VCW'(0) : v + VCW'(1);
  endfunction

  logic [VC_NUM-1:0][FLIT_SIZE-1:0] head_s;
  logic [VC_NUM-1:0][ROUTE_LEN-1:0] calc_route_s;
  logic [VC_NUM-1:0][ROUTE_LEN-1:0] route_s;
  logic [VC_NUM-1:0]                empty_s;
  logic [VC_NUM-1:0]                full_s;
  logic [VC_NUM-1:0]                elig_s;
  logic [VC_NUM-1:0]                wr_en_s;
  logic [VC_NUM-1:0]                pop_s;
  logic [VCW-1:0]                   grant_s;
  logic                             grant_found_s;
  logic                             ej_fire_s;
  logic                             ej_tail_s;

  arb_state_e     arb_state_q;
  logic [VCW-1:0] lock_vc_q;
  logic [VCW-1:0] rr_ptr_q;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    logic [FLIT_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [ROUTE_LEN-1:0] route_reg_q;

    assign head_s[v]       = mem_q[rd_ptr_q];
    assign empty_s[v]      = (cnt_q == CW'(0));
    assign full_s[v]       = (cnt_q == CW'(FIFO_DEPTH));
    assign calc_route_s[v] = route_of(head_s[v][COORD_W-1:0],
                                      head_s[v][2*COORD_W-1:COORD_W],
                                      head_s[v][3*COORD_W-1:2*COORD_W]);
    // A head at the FIFO front routes itself; anything else follows its packet's head.
    assign route_s[v]      = (!empty_s[v] && head_s[v][FLIT_SIZE-1]) ? calc_route_s[v]
                                                                      : route_reg_q;
    assign out_valid[v]    = !empty_s[v] && (route_s[v] != R_LOCAL);
    assign elig_s[v]       = !empty_s[v] && (route_s[v] == R_LOCAL);
    assign link_avail[v]   = rst && !full_s[v];
    assign wr_en_s[v]      = link_valid && (link_vc == VCW'(v)) && link_avail[v];
    assign pop_s[v]        = (out_valid[v] && out_avail[v]) ||
                             (ej_fire_s && (eject_vc == VCW'(v)));
    assign cnt_d           = cnt_q + CW'(wr_en_s[v]) - CW'(pop_s[v]);

    // Flit storage; contents are don't-care until the occupancy says otherwise.
    always_ff @(posedge clk) begin
      if (wr_en_s[v]) begin
        mem_q[wr_ptr_q] <= link_flit;
      end
    end

    // Pointers, occupancy and the per-VC packet route register.
    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr_q    <= PW'(0);
        rd_ptr_q    <= PW'(0);
        cnt_q       <= CW'(0);
        route_reg_q <= R_LOCAL;
      end else begin
        if (wr_en_s[v]) begin
          wr_ptr_q <= ptr_inc(wr_ptr_q);
        end
        if (pop_s[v]) begin
          rd_ptr_q <= ptr_inc(rd_ptr_q);
          if (head_s[v][FLIT_SIZE-1]) begin
            route_reg_q <= calc_route_s[v];
          end
        end
        cnt_q <= cnt_d;
      end
    end
  end

  assign out       = head_s;
  assign route_out = route_s;

  // Round-robin search for the first eligible VC starting at rr_ptr.
  always_comb begin : p_grant
    logic [VCW-1:0] cand;
    cand          = rr_ptr_q;
    grant_s       = rr_ptr_q;
    grant_found_s = 1'b0;
    for (int i = 0; i < VC_NUM; i++) begin
      grant_s       = (!grant_found_s && elig_s[cand]) ? cand : grant_s;
      grant_found_s = grant_found_s | elig_s[cand];
      cand          = vc_inc(cand);
    end
  end

  // Eject port selection: a locked packet owns the port until its tail leaves.
  always_comb begin
    eject_vc    = grant_s;
    eject_valid = grant_found_s;
    if (arb_state_q == ARB_LOCKED) begin
      eject_vc    = lock_vc_q;
      eject_valid = elig_s[lock_vc_q];
    end else begin
      eject_vc    = grant_s;
      eject_valid = grant_found_s;
    end
  end

  assign eject_flit = head_s[eject_vc];
  assign ej_fire_s  = eject_valid && eject_avail;
  assign ej_tail_s  = eject_flit[FLIT_SIZE-2];

  // Eject arbiter state machine.
  always_ff @(posedge clk) begin
    if (!rst) begin
      arb_state_q <= ARB_IDLE;
      lock_vc_q   <= VCW'(0);
      rr_ptr_q    <= VCW'(0);
    end else if (ej_fire_s) begin
      case (arb_state_q)
        ARB_IDLE: begin
          if (ej_tail_s) begin
            rr_ptr_q <= vc_inc(eject_vc);
          end else begin
            arb_state_q <= ARB_LOCKED;
            lock_vc_q   <= eject_vc;
          end
        end
        ARB_LOCKED: begin
          if (ej_tail_s) begin
            arb_state_q <= ARB_IDLE;
            rr_ptr_q    <= vc_inc(lock_vc_q);
          end
        end
        default: arb_state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_unit.sv
// Scoreboard bench for input_unit: per-VC expected-flit queues filled by the
// stimulus, drained by a negedge monitor that also predicts the eject order.
module tb_input_unit;

  localparam int DEPTH = 4;
  localparam int CX = 1;
  localparam int CY = 1;
  localparam int CZ = 1;

  typedef struct packed {
    logic [63:0] flit;
    logic [2:0]  route;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         link_valid = 1'b0;
  logic [0:0]   link_vc = 1'b0;
  logic [63:0]  link_flit = 64'd0;
  logic [1:0]   link_avail;
  logic [127:0] out;
  logic [5:0]   route_out;
  logic [1:0]   out_valid;
  logic [1:0]   out_avail = 2'b00;
  logic         eject_valid;
  logic [0:0]   eject_vc;
  logic [63:0]  eject_flit;
  logic         eject_avail = 1'b0;

  input_unit #(.CUR_X(CX), .CUR_Y(CY), .CUR_Z(CZ)) dut (
    .clk(clk), .rst(rst),
    .link_valid(link_valid), .link_vc(link_vc), .link_flit(link_flit),
    .link_avail(link_avail),
    .out(out), .route_out(route_out), .out_valid(out_valid), .out_avail(out_avail),
    .eject_valid(eject_valid), .eject_vc(eject_vc), .eject_flit(eject_flit),
    .eject_avail(eject_avail)
  );

  always #5 clk = ~clk;

  ent_t        fq [2][$];
  logic [2:0]  cur_route [2];
  bit          locked;
  int          lock_vc;
  int          rr;
  bit          mon_en;
  int          total;
  int          bad;
  bit          pend_v;
  int          pend_vc;
  logic [63:0] pend_f;
  int          seq;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_route(input logic [63:0] f);
    int x, y, z;
    x = int'(f[3:0]);
    y = int'(f[7:4]);
    z = int'(f[11:8]);
    if (x > CX) return 3'd1;
    if (x < CX) return 3'd4;
    if (y > CY) return 3'd2;
    if (y < CY) return 3'd5;
    if (z > CZ) return 3'd3;
    if (z < CZ) return 3'd6;
    return 3'd0;
  endfunction

  function automatic logic [63:0] mk(input bit h, input bit t, input int x, input int y, input int z);
    seq++;
    return {h, t, 50'(seq), 4'(z), 4'(y), 4'(x)};
  endfunction

  function automatic bit elig(input int v);
    return (fq[v].size() > 0) && (fq[v][0].route == 3'd0);
  endfunction

  // A body flit inherits the route of the most recent head written to its VC.
  task automatic commit_push(input int v, input logic [63:0] f);
    ent_t e;
    if (f[63]) cur_route[v] = ref_route(f);
    e.flit  = f;
    e.route = cur_route[v];
    fq[v].push_back(e);
  endtask

  task automatic step(input bit lv, input int lvc, input logic [63:0] lf,
                      input logic [1:0] oa, input bit ea, input bit r);
    @(posedge clk);
    #1;
    if (pend_v) commit_push(pend_vc, pend_f);
    pend_v      = lv && r && (fq[lvc].size() < DEPTH);
    pend_vc     = lvc;
    pend_f      = lf;
    link_valid  = lv;
    link_vc     = 1'(lvc);
    link_flit   = lf;
    out_avail   = oa;
    eject_avail = ea;
    rst         = r;
  endtask

  task automatic idle(input int n, input logic [1:0] oa, input bit ea);
    for (int i = 0; i < n; i++) step(1'b0, 0, 64'd0, oa, ea, 1'b1);
  endtask

  // Monitor: compare what the DUT presents, then retire the transfers of the coming edge.
  always @(negedge clk) begin : mon
    logic [1:0] exp_la, exp_ov;
    bit         exp_ev;
    int         exp_evc, c;
    ent_t       e;
    if (mon_en) begin
      for (int v = 0; v < 2; v++) begin
        exp_la[v] = rst && (fq[v].size() < DEPTH);
        exp_ov[v] = (fq[v].size() > 0) && (fq[v][0].route != 3'd0);
      end
      chk("link_avail", 64'(link_avail), 64'(exp_la));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      for (int v = 0; v < 2; v++) begin
        if (exp_ov[v]) begin
          chk("route_out", 64'(route_out[v*3 +: 3]), 64'(fq[v][0].route));
          chk("out_flit", out[v*64 +: 64], fq[v][0].flit);
        end
      end
      exp_ev  = 1'b0;
      exp_evc = 0;
      if (locked) begin
        exp_evc = lock_vc;
        exp_ev  = elig(lock_vc);
      end else begin
        for (int i = 0; i < 2; i++) begin
          c = (rr + i) % 2;
          if (!exp_ev && elig(c)) begin
            exp_ev  = 1'b1;
            exp_evc = c;
          end
        end
      end
      chk("eject_valid", 64'(eject_valid), 64'(exp_ev));
      if (exp_ev) begin
        chk("eject_vc", 64'(eject_vc), 64'(exp_evc));
        chk("eject_flit", eject_flit, fq[exp_evc][0].flit);
      end
      if (!rst) begin
        for (int v = 0; v < 2; v++) begin
          fq[v].delete();
          cur_route[v] = 3'd0;
        end
        locked = 1'b0;
        lock_vc = 0;
        rr = 0;
      end else begin
        for (int v = 0; v < 2; v++) begin
          if (exp_ov[v] && out_avail[v]) void'(fq[v].pop_front());
        end
        if (exp_ev && eject_avail) begin
          e = fq[exp_evc].pop_front();
          if (!locked) begin
            if (e.flit[62]) rr = (exp_evc + 1) % 2;
            else begin
              locked  = 1'b1;
              lock_vc = exp_evc;
            end
          end else if (e.flit[62]) begin
            locked = 1'b0;
            rr     = (lock_vc + 1) % 2;
          end
        end
      end
    end
  end

  initial begin
    bit h, t;
    int x, y, z;
    cur_route[0] = 3'd0;
    cur_route[1] = 3'd0;
    step(1'b0, 0, 64'd0, 2'b00, 1'b0, 1'b0);
    mon_en = 1'b1;
    step(1'b0, 0, 64'd0, 2'b00, 1'b0, 1'b0);
    idle(2, 2'b00, 1'b0);

    // Single-flit packet heading +X on VC0, held one cycle then popped.
    step(1'b1, 0, mk(1'b1, 1'b1, 3, 1, 1), 2'b00, 1'b0, 1'b1);
    idle(1, 2'b00, 1'b0);
    idle(1, 2'b01, 1'b0);
    idle(2, 2'b00, 1'b0);

    // Three-flit +Z packet on VC1; the body carries misleading coordinates.
    step(1'b1, 1, mk(1'b1, 1'b0, 1, 1, 6), 2'b00, 1'b0, 1'b1);
    step(1'b1, 1, mk(1'b0, 1'b0, 9, 0, 0), 2'b00, 1'b0, 1'b1);
    step(1'b1, 1, mk(1'b0, 1'b1, 0, 0, 0), 2'b00, 1'b0, 1'b1);
    idle(2, 2'b00, 1'b0);
    idle(4, 2'b10, 1'b0);

    // Fill VC0, attempt an overfill, then pop and write in the same cycle.
    for (int i = 0; i < 5; i++) step(1'b1, 0, mk(1'b1, 1'b1, 1, 0, 1), 2'b00, 1'b0, 1'b1);
    idle(1, 2'b00, 1'b0);
    idle(1, 2'b01, 1'b0);
    step(1'b1, 0, mk(1'b1, 1'b1, 1, 3, 1), 2'b01, 1'b0, 1'b1);
    step(1'b1, 0, mk(1'b1, 1'b1, 1, 1, 0), 2'b00, 1'b0, 1'b1);
    idle(2, 2'b00, 1'b0);
    idle(6, 2'b01, 1'b0);

    // Two local 2-flit packets interleaved on the link, eject always ready.
    step(1'b1, 0, mk(1'b1, 1'b0, 1, 1, 1), 2'b00, 1'b0, 1'b1);
    step(1'b1, 1, mk(1'b1, 1'b0, 1, 1, 1), 2'b00, 1'b0, 1'b1);
    step(1'b1, 0, mk(1'b0, 1'b1, 1, 1, 1), 2'b00, 1'b0, 1'b1);
    step(1'b1, 1, mk(1'b0, 1'b1, 1, 1, 1), 2'b00, 1'b0, 1'b1);
    idle(6, 2'b00, 1'b1);

    // Same traffic with the local sink toggling every cycle.
    step(1'b1, 0, mk(1'b1, 1'b0, 1, 1, 1), 2'b00, 1'b0, 1'b1);
    step(1'b1, 1, mk(1'b1, 1'b0, 1, 1, 1), 2'b00, 1'b0, 1'b1);
    step(1'b1, 0, mk(1'b0, 1'b1, 1, 1, 1), 2'b00, 1'b0, 1'b1);
    step(1'b1, 1, mk(1'b0, 1'b1, 1, 1, 1), 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) idle(1, 2'b00, 1'(i % 2));

    // Lock the eject port on VC0, leave three flits buffered, then reset.
    step(1'b1, 0, mk(1'b1, 1'b0, 1, 1, 1), 2'b00, 1'b0, 1'b1);
    step(1'b1, 0, mk(1'b0, 1'b0, 1, 1, 1), 2'b00, 1'b0, 1'b1);
    step(1'b1, 0, mk(1'b0, 1'b0, 1, 1, 1), 2'b00, 1'b0, 1'b1);
    step(1'b1, 1, mk(1'b1, 1'b1, 1, 1, 1), 2'b00, 1'b0, 1'b1);
    idle(1, 2'b00, 1'b1);
    idle(1, 2'b00, 1'b0);
    step(1'b0, 0, 64'd0, 2'b11, 1'b1, 1'b0);
    step(1'b1, 1, mk(1'b1, 1'b1, 1, 1, 1), 2'b11, 1'b1, 1'b0);
    idle(2, 2'b00, 1'b0);
    step(1'b1, 1, mk(1'b1, 1'b1, 1, 1, 1), 2'b00, 1'b1, 1'b1);
    step(1'b1, 0, mk(1'b1, 1'b1, 1, 1, 1), 2'b00, 1'b1, 1'b1);
    idle(4, 2'b00, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      h = 1'($urandom_range(0, 1));
      t = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        x = CX; y = CY; z = CZ;
      end else begin
        x = $urandom_range(0, 3);
        y = $urandom_range(0, 3);
        z = $urandom_range(0, 3);
      end
      step(1'($urandom_range(0, 9) < 7), $urandom_range(0, 1), mk(h, t, x, y, z),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 299) != 0));
    end
    idle(8, 2'b11, 1'b1);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
